cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 19 +
 rtl/lru_table.sv | 26 ++
 rtl/cache_controller.sv | 163 ++++++++++++++++
 tb/tb_cache_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared widths and controller state type for the two-way cache controller
// and the cache array it drives.
package cache_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int TAG_WIDTH    = 27;
    localparam int SET_WIDTH    = 3;
    localparam int OFFSET_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        MEM_RD = 3'd2,
        FILL   = 3'd3,
        MEM_WR = 3'd4,
        RESP   = 3'd5
    } cache_state_t;

endpackage

// File: rtl/lru_table.sv
// One LRU bit per set of the two-way cache; the bit names the next victim way.
module lru_table #(
    parameter int SET_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SET_WIDTH-1:0] rd_set,
    output logic                 rd_bit,
    input  logic                 wr_en,
    input  logic [SET_WIDTH-1:0] wr_set,
    input  logic                 wr_bit
);

    logic [(2**SET_WIDTH)-1:0] bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits <= '0;
        end else if (wr_en) begin
            bits[wr_set] <= wr_bit;
        end
    end

    assign rd_bit = bits[rd_set];

endmodule

// File: rtl/cache_controller.sv
// Two-way write-through, no-write-allocate cache controller: serialises one CPU
// request at a time through tag lookup, line fill from memory and LRU upkeep.
module cache_controller #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int TAG_WIDTH    = 27,
    parameter  int SET_WIDTH    = 3,
    parameter  int OFFSET_WIDTH = 2,
    localparam int ADDR_WIDTH   = TAG_WIDTH + SET_WIDTH + OFFSET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  hit_0,
    input  logic                  hit_1,
    input  logic [DATA_WIDTH-1:0] cache_rdata,
    output logic                  fill_en,
    output logic                  fill_way,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  wr_en,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    import cache_pkg::*;

    cache_state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                 hit;
    logic                 hit_way;
    logic [SET_WIDTH-1:0] set;
    logic                 lru_bit;
    logic                 lru_wr_en;
    logic                 lru_wr_bit;
    logic [ADDR_WIDTH-1:0] line_addr;

    // A double hit resolves to way 0.
    assign hit       = hit_0 | hit_1;
    assign hit_way   = ~hit_0 & hit_1;
    assign set       = addr_q[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH];
    assign line_addr = {addr_q[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign cache_addr = addr_q;

    lru_table #(
        .SET_WIDTH(SET_WIDTH)
    ) u_lru (
        .clk    (clk),
        .rst    (rst),
        .rd_set (set),
        .rd_bit (lru_bit),
        .wr_en  (lru_wr_en),
        .wr_set (set),
        .wr_bit (lru_wr_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request latch and response data capture; writes keep data_q at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                data_q  <= '0;
            end else if (state == LOOKUP && !we_q && hit) begin
                data_q <= cache_rdata;
            end else if (state == MEM_RD && mem_ack) begin
                data_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = LOOKUP;
            LOOKUP: begin
                if (we_q)     state_next = MEM_WR;
                else if (hit) state_next = RESP;
                else          state_next = MEM_RD;
            end
            MEM_RD:  if (mem_ack) state_next = FILL;
            FILL:    state_next = RESP;
            MEM_WR:  if (mem_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        fill_en    = 1'b0;
        fill_way   = 1'b0;
        fill_data  = '0;
        wr_en      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        lru_wr_en  = 1'b0;
        lru_wr_bit = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            LOOKUP: begin
                wr_en      = we_q & hit;
                lru_wr_en  = hit;
                lru_wr_bit = ~hit_way;
            end
            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = line_addr;
            end
            FILL: begin
                fill_en    = 1'b1;
                fill_way   = lru_bit;
                fill_data  = data_q;
                lru_wr_en  = 1'b1;
                lru_wr_bit = ~lru_bit;
            end
            MEM_WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_addr;
                mem_wdata = wdata_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = data_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed table from reset, a mid-miss reset
// sequence, then random transactions against a per-set LRU reference model.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid;
    logic [31:0] resp_rdata, cache_addr;
    logic        hit_0, hit_1;
    logic [31:0] cache_rdata;
    logic        fill_en, fill_way, wr_en;
    logic [31:0] fill_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .cache_addr(cache_addr), .hit_0(hit_0), .hit_1(hit_1), .cache_rdata(cache_rdata),
        .fill_en(fill_en), .fill_way(fill_way), .fill_data(fill_data), .wr_en(wr_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        h0;
        logic        h1;
        logic [31:0] crdata;
        int          d;
        logic [31:0] mrdata;
        logic        hold;
        logic [31:0] exp_data;
        logic        exp_fill;
        logic        exp_way;
        logic        exp_wr;
        logic        exp_mem;
        int          exp_lat;
    } vec_t;

    bit lru_model [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected behaviour straight from the cache policy: hits respond from the
    // array, read misses fill the victim way, writes go through to memory.
    function automatic vec_t predict(input vec_t v);
        vec_t r = v;
        int   s = int'(v.addr[4:2]);
        bit   hit = v.h0 | v.h1;
        bit   way = v.h0 ? 1'b0 : 1'b1;
        r.exp_fill = 0; r.exp_way = 0; r.exp_wr = 0; r.exp_mem = 0;
        if (!v.we && hit) begin
            r.exp_data = v.crdata;
            r.exp_lat  = 2;
            lru_model[s] = !way;
        end else if (!v.we) begin
            r.exp_fill = 1;
            r.exp_way  = lru_model[s];
            r.exp_data = v.mrdata;
            r.exp_mem  = 1;
            r.exp_lat  = v.d + 4;
            lru_model[s] = !lru_model[s];
        end else begin
            r.exp_wr   = hit;
            r.exp_mem  = 1;
            r.exp_data = 32'h0;
            r.exp_lat  = v.d + 3;
            if (hit) lru_model[s] = !way;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic h0, input logic h1, input logic [31:0] crdata,
                                input int d, input logic [31:0] mrdata, input logic hold,
                                input logic [31:0] exp_data, input logic exp_fill,
                                input logic exp_way, input logic exp_wr, input logic exp_mem,
                                input int exp_lat);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.h0 = h0; v.h1 = h1;
        v.crdata = crdata; v.d = d; v.mrdata = mrdata; v.hold = hold;
        v.exp_data = exp_data; v.exp_fill = exp_fill; v.exp_way = exp_way;
        v.exp_wr = exp_wr; v.exp_mem = exp_mem; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int  cyc = 0;
        int  mcyc = 0;
        int  fills = 0;
        int  wrs = 0;
        bit  got_resp = 0;
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        mem_ack = 0;
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        hit_0 = v.h0; hit_1 = v.h1; cache_rdata = v.crdata;
        while (!got_resp && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ack = 0;
            if (!v.hold) req_valid = 0;
            if (cyc == 1) chk("cache_addr", cache_addr, v.addr);
            if (wr_en) wrs++;
            if (fill_en) begin
                fills++;
                chk("fill_way", fill_way, v.exp_way);
                chk("fill_data", fill_data, v.mrdata);
                chk("fill_wr_excl", wr_en, 0);
            end
            if (mem_req) begin
                mcyc++;
                chk("mem_we", mem_we, v.we);
                chk("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
                if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
                if (mcyc == v.d + 1) begin
                    mem_ack = 1;
                    mem_rdata = v.mrdata;
                end
            end
            if (resp_valid) begin
                got_resp = 1;
                chk("resp_latency", cyc, v.exp_lat);
                chk("resp_rdata", resp_rdata, v.exp_data);
                if (v.hold) chk("ready_in_resp", req_ready, 0);
            end
        end
        chk("resp_seen", got_resp, 1);
        chk("fill_count", fills, v.exp_fill);
        chk("wr_en_count", wrs, v.exp_wr);
        chk("mem_req_cycles", mcyc, v.exp_mem ? v.d + 1 : 0);
        @(negedge clk);
        mem_ack = 0;
        chk("resp_one_cycle", resp_valid, 0);
        chk("ready_after_resp", req_ready, 1);
        req_valid = 0;
    endtask

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        hit_0 = 0; hit_1 = 0; cache_rdata = 0; mem_ack = 0; mem_rdata = 0;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_fill_en", fill_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_fill_way", fill_way, 0);
        chk("rst_cache_addr", cache_addr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        @(negedge clk);
        rst = 0;

        //            we  addr          wdata         h0 h1 crdata        d  mrdata        hold exp_data      fill way wr mem lat
        tbl[0] = mk(0, 32'h0000_0040, 32'h0,        0, 0, 32'h0,        2, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1, 0, 0, 1, 6);
        tbl[1] = mk(0, 32'h0000_0060, 32'h0,        0, 0, 32'h0,        0, 32'h1111_1111, 0, 32'h1111_1111, 1, 1, 0, 1, 4);
        tbl[2] = mk(0, 32'h0000_0080, 32'h0,        0, 0, 32'h0,        1, 32'h2222_2222, 0, 32'h2222_2222, 1, 0, 0, 1, 5);
        tbl[3] = mk(0, 32'h0000_0000, 32'h0,        0, 1, 32'h1234_5678, 0, 32'h0,        0, 32'h1234_5678, 0, 0, 0, 0, 2);
        tbl[4] = mk(0, 32'h0000_00A0, 32'h0,        0, 0, 32'h0,        0, 32'h3333_3333, 0, 32'h3333_3333, 1, 0, 0, 1, 4);
        tbl[5] = mk(1, 32'h0000_0010, 32'hA5A5_A5A5, 1, 0, 32'h0,       1, 32'h0,        0, 32'h0,         0, 0, 1, 1, 4);
        tbl[6] = mk(0, 32'h0000_0030, 32'h0,        0, 0, 32'h0,        0, 32'h4444_4444, 0, 32'h4444_4444, 1, 1, 0, 1, 4);
        tbl[7] = mk(1, 32'h0000_0014, 32'h5A5A_5A5A, 0, 0, 32'h0,       2, 32'h0,        0, 32'h0,         0, 0, 0, 1, 5);
        tbl[8] = mk(0, 32'h0000_0008, 32'h0,        1, 1, 32'hCAFE_F00D, 0, 32'h0,        1, 32'hCAFE_F00D, 0, 0, 0, 0, 2);
        tbl[9] = mk(0, 32'h0000_0028, 32'h0,        0, 0, 32'h0,        0, 32'h5555_5555, 0, 32'h5555_5555, 1, 1, 0, 1, 4);
        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // Reset in the middle of a read miss; a late ack must be ignored.
        @(negedge clk);
        req_valid = 1; req_we = 0; req_addr = 32'h0000_00C0; hit_0 = 0; hit_1 = 0;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        chk("mid_mem_req", mem_req, 1);
        rst = 1;
        #1;
        chk("rst_drop_mem_req", mem_req, 0);
        chk("rst_to_idle", req_ready, 1);
        chk("rst_clear_addr", cache_addr, 0);
        @(negedge clk);
        rst = 0;
        mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ack = 0;
            chk("stray_fill_en", fill_en, 0);
            chk("stray_resp_valid", resp_valid, 0);
            chk("stray_mem_req", mem_req, 0);
        end

        for (int s = 0; s < 8; s++) lru_model[s] = 0;
        for (int i = 0; i < 150; i++) begin
            vec_t v;
            v.we = 1'($urandom_range(0, 1));
            v.addr = $urandom;
            v.wdata = $urandom;
            v.h0 = 1'($urandom_range(0, 1));
            v.h1 = 1'($urandom_range(0, 1));
            v.crdata = $urandom;
            v.d = $urandom_range(0, 4);
            v.mrdata = $urandom;
            v.hold = ($urandom_range(0, 3) == 0);
            run_vec(predict(v));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
